load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory-stage consumer of the execution stage's address (alu_y) and forwarded store data (rrd2_fwd).
//  Turns a load/store into a registered req/ack data-bus transaction, builds byte enables, and
//  aligns/sign-extends load data. Stalls the pipeline while a transaction is outstanding.
//  Reports misaligned and bus-fault exceptions.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in REQ without ack/err before a bus fault is forced; 0 = no timeout
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  reset           in   1   asynchronous, active-high reset
//  req_valid       in   1   EX/MEM register holds a valid instruction
//  is_load         in   1   instruction is a load
//  is_store        in   1   instruction is a store (never both with is_load)
//  mem_op          in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
//  addr            in   32  effective byte address (ALU result)
//  wdata           in   32  store data, already forwarded
//  flush           in   1   kill current instruction (trap/redirect)
//  bus_req         out  1   bus request, held until ack/err/timeout
//  bus_we          out  1   1 = write
//  bus_addr        out  32  word address {addr[31:2],2'b00}
//  bus_wdata       out  32  lane-replicated store data
//  bus_be          out  4   byte enables
//  bus_ack         in   1   transfer complete; bus_rdata valid this cycle
//  bus_err         in   1   transfer failed
//  bus_rdata       in   32  read word
//  stall           out  1   hold IF..MEM pipeline registers
//  load_data       out  32  aligned, extended load result (to WB / m_regwd path)
//  load_valid      out  1   one-cycle pulse, load_data valid
//  exc_misaligned  out  1   misaligned access, combinational, same cycle as request
//  exc_bus         out  1   one-cycle pulse: bus_err or timeout
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0, kill flag 0; bus_req/bus_we/bus_be/bus_addr/bus_wdata/
//   load_data 0, load_valid 0, exc_bus 0. stall and exc_misaligned forced 0 while reset is high.
//   Reset asserted mid-transaction drops bus_req immediately; no response is produced.
//  Accept (IDLE): op = req_valid & (is_load|is_store) & ~flush.
//   Misaligned: H/HU/SH with addr[0]=1, or W with addr[1:0]!=0. exc_misaligned=op&misaligned.
//   No bus access, no stall, state stays IDLE.
//   Aligned op: stall=1 in this cycle; bus_* registered; next state REQ.
//  Byte enables: B: 4'b0001<<addr[1:0]; H: addr[1] ? 4'b1100 : 4'b0011; W: 4'b1111 (loads too).
//  Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
//  REQ: bus_req=1; bus_addr/bus_we/bus_be/bus_wdata stable; stall=1; counter increments each cycle.
//   bus_ack -> RESP; load: load_data <= bus_rdata >> (8*addr[1:0]), then sign-extend (B,H) or
//   zero-extend (BU,HU); load_valid <= is_load.
//   bus_err, or counter==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0) -> RESP, exc_bus <= 1.
//   ack and err in the same cycle: err wins, no load_valid.
//   On leaving REQ: bus_req <= 0, counter <= 0.
//  Flush while in REQ sets kill flag; transaction still completes (no bus abort),
//   but load_valid and exc_bus are suppressed.
//  RESP (1 cycle): stall=0 so the pipeline advances; req_valid ignored (same instruction);
//   pulses drop next cycle; kill cleared; -> IDLE.
//  Latency: accept->bus_req 1 cycle; ack->load_valid 1 cycle. Min 3 cycles per access
//   (IDLE, REQ, RESP); one outstanding transaction max.
// TESTING
//  LB addr 0x1003, rdata 0x80AABBCC, ack in 1st REQ cycle -> be 4'b1000, bus_addr 0x1000,
//   load_data 0xFFFFFF80, load_valid 1 cycle, stall high 2 cycles
//  SH addr 0x2002, wdata 0x1234ABCD -> bus_we 1, be 4'b1100, bus_wdata 0xABCDABCD, no load_valid
//  LW addr 0x3001 -> exc_misaligned=1 same cycle, bus_req never rises, stall 0
//  LHU addr 0x40, no ack, TIMEOUT_CYCLES 16 -> bus_req high 16 cycles, then exc_bus pulse,
//   stall releases
//  LW, flush in 2nd REQ cycle, ack in 3rd -> no load_valid, no exc_bus, FSM returns to IDLE
//  Reset asserted during REQ -> bus_req 0 and stall 0 asynchronously, IDLE after release

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: registers a req/ack bus transaction, builds byte enables,
// replicates store data, aligns and extends load data, and reports misaligned/bus faults.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        exc_misaligned_o,
    output logic        exc_bus_o
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   ldata_q, ldata_d;
    logic          lvalid_q, lvalid_d;
    logic          excbus_q, excbus_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    off_q, off_d;
    logic          ld_q, ld_d;

    logic          op, mis, timeout, fault, finish, drop;
    logic [3:0]    be_new;
    logic [31:0]   wd_new, shifted, ext;

    // Size decode uses funct3[1:0]; bit 2 only selects zero-extension for loads.
    always_comb begin
        op = req_valid_i & (is_load_i | is_store_i) & ~flush_i;
        case (mem_op_i[1:0])
            2'b00: begin
                mis    = 1'b0;
                be_new = 4'b0001 << addr_i[1:0];
                wd_new = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                mis    = addr_i[0];
                be_new = addr_i[1] ? 4'b1100 : 4'b0011;
                wd_new = {2{wdata_i[15:0]}};
            end
            default: begin
                mis    = |addr_i[1:0];
                be_new = 4'b1111;
                wd_new = wdata_i;
            end
        endcase
    end

    always_comb begin
        shifted = bus_rdata_i >> {off_q, 3'b000};
        case (op_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign fault   = bus_err_i | timeout;
    assign finish  = bus_ack_i | fault;
    // A flush arriving on the completing cycle kills the response just like an earlier one.
    assign drop    = kill_q | flush_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kill_d   = kill_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        ldata_d  = ldata_q;
        lvalid_d = 1'b0;
        excbus_d = 1'b0;
        op_d     = op_q;
        off_d    = off_q;
        ld_d     = ld_q;
        case (state_q)
            IDLE: begin
                if (op && !mis) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = is_store_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = wd_new;
                    be_d    = be_new;
                    op_d    = mem_op_i;
                    off_d   = addr_i[1:0];
                    ld_d    = is_load_i;
                    cnt_d   = '0;
                    kill_d  = 1'b0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (flush_i)
                    kill_d = 1'b1;
                if (finish) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    if (fault) begin
                        excbus_d = ~drop;
                    end else begin
                        lvalid_d = ld_q & ~drop;
                        if (ld_q)
                            ldata_d = ext;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            kill_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            ldata_q  <= '0;
            lvalid_q <= 1'b0;
            excbus_q <= 1'b0;
            op_q     <= '0;
            off_q    <= '0;
            ld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kill_q   <= kill_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            ldata_q  <= ldata_d;
            lvalid_q <= lvalid_d;
            excbus_q <= excbus_d;
            op_q     <= op_d;
            off_q    <= off_d;
            ld_q     <= ld_d;
        end
    end

    assign bus_req_o        = req_q;
    assign bus_we_o         = we_q;
    assign bus_addr_o       = addr_q;
    assign bus_wdata_o      = wdata_q;
    assign bus_be_o         = be_q;
    assign load_data_o      = ldata_q;
    assign load_valid_o     = lvalid_q;
    assign exc_bus_o        = excbus_q;
    assign stall_o          = ~reset_i & ((state_q == REQ) | ((state_q == IDLE) & op & ~mis));
    assign exc_misaligned_o = ~reset_i & (state_q == IDLE) & op & mis;
endmodule
